// File: rtl/nn_zoffset_decode.sv
// nn_zoffset_decode
// -----------------------------------------------------------------------------
// Stochastic-to-binary decoder for sign-magnitude stochastic streams, such as
// the z-offset stream at the output of the z-offset path. It counts signed ones
// over a fixed window of 2^WIN_LOG2 clocks and presents the result as a
// two's-complement binary count. The result is delivered with a
// start/valid/ack handshake.
//
// Parameters
//   WIN_LOG2 : log2 of the window length in clocks
//   OUT_W    : width of the signed result, must be >= WIN_LOG2+2
//
// Ports
//   CLK     in   system clock, rising edge
//   INIT    in   asynchronous active-low reset
//   START   in   request a new window (taken in IDLE, or in DONE with ACK)
//   IN      in   stochastic magnitude bit
//   SIGN_IN in   sign of the current IN bit (1 = negative)
//   ACK     in   consumer has taken VALUE (taken only in DONE)
//   VALUE   out  signed count of the last completed window
//   VALID   out  VALUE is fresh and not yet acknowledged
//   BUSY    out  a window is being accumulated
// -----------------------------------------------------------------------------
module nn_zoffset_decode #(
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = WIN_LOG2 + 2
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             START,
    input  logic             IN,
    input  logic             SIGN_IN,
    input  logic             ACK,
    output logic [OUT_W-1:0] VALUE,
    output logic             VALID,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter index of the final sample of a window.
    localparam logic [WIN_LOG2-1:0] LAST_SAMPLE = '1;
    localparam logic [OUT_W-1:0]    PLUS_ONE    = OUT_W'(1);
    localparam logic [OUT_W-1:0]    MINUS_ONE   = '1;

    state_t              state;
    logic [WIN_LOG2-1:0] sample_count;
    logic [OUT_W-1:0]    accum;
    logic [OUT_W-1:0]    delta;
    logic [OUT_W-1:0]    accum_next;

    // Contribution of the current sample. The accumulator spans
    // [-2^WIN_LOG2, +2^WIN_LOG2] and OUT_W >= WIN_LOG2+2 bits,
    // so a plain modular add can never overflow.
    always_comb begin
        delta = '0;
        if (IN) begin
            delta = SIGN_IN ? MINUS_ONE : PLUS_ONE;
        end
        accum_next = accum + delta;
    end

    // Single registered FSM. All outputs are flops, so no input reaches an
    // output combinationally.
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state        <= IDLE;
            sample_count <= '0;
            accum        <= '0;
            VALUE        <= '0;
            VALID        <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The START edge only arms the window. The first sample
                    // is taken on the following edge.
                    if (START) begin
                        state        <= ACCUM;
                        sample_count <= '0;
                        accum        <= '0;
                        BUSY         <= 1'b1;
                    end
                end

                ACCUM: begin
                    // START and ACK are deliberately ignored here.
                    sample_count <= sample_count + 1'b1;
                    accum        <= accum_next;
                    if (sample_count == LAST_SAMPLE) begin
                        VALUE <= accum_next;
                        VALID <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // The result is held until acknowledged. ACK together with
                    // START chains straight into the next window, so no cycle
                    // is lost between back-to-back windows.
                    if (ACK) begin
                        VALID <= 1'b0;
                        if (START) begin
                            state        <= ACCUM;
                            sample_count <= '0;
                            accum        <= '0;
                            BUSY         <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nn_zoffset_decode.md
Name: nn_zoffset_decode

Overview:
- Stochastic-to-binary decoder for sign-magnitude stochastic streams, e.g. the offset z stream `zd` with its sign.
- Counts signed ones over a fixed window of 2^WIN_LOG2 clocks and returns a signed binary count.
- Provides a start/valid/ack handshake.
- Sits at the output side of the z-offset path, so training/monitor logic can read z+d as a binary number.

Parameters:
- WIN_LOG2, 8, log2 of the accumulation window length in clocks (window = 2^WIN_LOG2 samples).
- OUT_W, WIN_LOG2+2, width of the signed result. Must be >= WIN_LOG2+2.

Ports:
- CLK  input  1  system clock, rising edge.
- INIT  input  1  asynchronous active-low reset.
- START  input  1  request a new accumulation window. Sampled only in IDLE, or in DONE together with ACK.
- IN  input  1  stochastic magnitude bit.
- SIGN_IN  input  1  sign of the current IN bit (1 = negative).
- ACK  input  1  consumer has taken VALUE. Sampled only in DONE.
- VALUE  output  OUT_W  two's-complement signed count of the last completed window.
- VALID  output  1  VALUE holds a fresh, unacknowledged result.
- BUSY  output  1  a window is being accumulated.

Behaviour:
- Reset (INIT=0, asynchronous):
  - State IDLE; sample counter = 0; accumulator = 0.
  - VALUE = 0, VALID = 0, BUSY = 0.
  - Reset asserted mid-window aborts the window. No VALID is produced and the partial sum is discarded.
- States: IDLE, ACCUM, DONE (registered FSM).
- IDLE:
  - START=1 at an edge → ACCUM next cycle; counter and accumulator cleared at that edge.
  - No sample is taken on the START edge.
- ACCUM:
  - Each rising edge takes one sample.
  - IN=1 & SIGN_IN=0 → accumulator +1. IN=1 & SIGN_IN=1 → accumulator −1. IN=0 → unchanged (SIGN_IN ignored).
  - Counter increments every sample and wraps to 0 on the last sample.
  - Exactly 2^WIN_LOG2 samples are taken: the first on the edge after the START edge, the last on edge 2^WIN_LOG2 after it.
  - On the last-sample edge:
    - VALUE is loaded with the accumulator including that last sample.
    - VALID goes 1, BUSY goes 0, state → DONE.
  - BUSY=1 throughout ACCUM.
  - START in ACCUM is ignored and is not queued.
- Latency: VALID rises 2^WIN_LOG2 edges after the START edge.
- DONE:
  - VALUE and VALID held stable indefinitely; the input stream is ignored.
  - ACK=1 & START=0 → IDLE; VALID=0 next cycle.
  - ACK=1 & START=1 → ACCUM directly (back-to-back windows); VALID=0 and BUSY=1 next cycle; accumulator and counter cleared.
  - START=1 without ACK → ignored; stay in DONE, no result is overwritten.
- ACK outside DONE is ignored.
- VALUE keeps the last result after ACK until the next window completes. It is never cleared except by reset.
- Arithmetic:
  - Accumulator range is [−2^WIN_LOG2, +2^WIN_LOG2] and is held in OUT_W-bit two's complement, so overflow is impossible by construction.
  - If OUT_W > WIN_LOG2+2, VALUE is sign-extended.
  - Counter is WIN_LOG2 bits wide.
- Signals in/out: no combinational path from any input to any output; all outputs are registered.

Test Plan (WIN_LOG2=4, window 16):
1. Reset, START pulse, IN=1 and SIGN_IN=0 for all 16 samples → VALID rises on the 16th edge after START, VALUE=+16 (6'sb010000), BUSY high for exactly 16 cycles.
2. IN=1, SIGN_IN=1 for 16 samples → VALUE=−16 (6'sb110000). Then stream IN=1 with SIGN_IN alternating 0,1 → VALUE=0. Then 12 positive ones, 4 zeros → VALUE=+12.
3. Hold result with ACK=0 for 40 cycles while toggling IN/SIGN_IN/START → VALUE and VALID unchanged, no new window. Then ACK alone → VALID=0 next cycle, VALUE retained, state IDLE.
4. In DONE assert ACK=1 and START=1 together with 16 positive ones following → VALID drops for exactly 16 cycles, then rises with VALUE=+16. No sample is lost or duplicated.
5. START pulses inside ACCUM at samples 3 and 9 → no restart, result equals the 16-sample sum of the original window. ACK pulses in IDLE/ACCUM have no effect.
6. Assert INIT low at sample 7 of a window → VALUE=0, VALID=0, BUSY=0 immediately (asynchronous). After release, a new START produces a correct full-window result with no residue from the aborted window.
